// File: rtl/coin_acceptor.sv
// Coin slot front end: per-sensor synchronise/debounce, accept/reject arbitration,
// coin FIFO and a paced emitter that drives single-cycle codes with an idle gap.

module coin_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_raw,
  output logic o_detect
);
  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [1:0]    r_sync;
  logic          r_armed;
  logic [CW-1:0] r_cnt;
  logic          w_s;

  assign w_s      = r_sync[1];
  // Counter tracks consecutive cycles at the level that would change the armed state:
  // high while armed (detect), low while disarmed (re-arm).
  assign o_detect = r_armed && (r_cnt == CW'(DEB_CYCLES));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync  <= '0;
      r_armed <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      if (r_cnt == CW'(DEB_CYCLES)) begin
        // The current sample already counts toward the new target level.
        r_armed <= !r_armed;
        r_cnt   <= (w_s == !r_armed) ? CW'(1) : '0;
      end else if (w_s == r_armed) begin
        r_cnt <= r_cnt + CW'(1);
      end else begin
        r_cnt <= '0;
      end
    end
  end
endmodule

module coin_acceptor #(
  parameter int DEB_CYCLES = 4,
  parameter int MIN_GAP    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             sensor2,
  input  logic                             sensor3,
  input  logic                             sensor4,
  input  logic                             enable,
  output logic [1:0]                       moneda,
  output logic                             coin_reject,
  output logic                             fifo_full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  pending
);
  localparam int NUM_SENS = 3;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH + 1);
  localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EMIT = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic [NUM_SENS-1:0] w_raw;
  logic [NUM_SENS-1:0] w_det;
  logic                w_any;
  logic                w_multi;
  logic                w_push;
  logic                w_pop;
  logic [1:0]          w_code;
  logic [PW-1:0]       w_pending_nxt;

  logic [1:0]          r_mem [FIFO_DEPTH];
  logic [AW-1:0]       r_wptr;
  logic [AW-1:0]       r_rptr;
  logic [1:0]          r_state;
  logic [GW-1:0]       r_gap;

  assign w_raw = {sensor4, sensor3, sensor2};

  coin_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb [NUM_SENS-1:0] (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_raw    (w_raw),
    .o_detect (w_det)
  );

  assign w_any   = |w_det;
  assign w_multi = (w_det[0] & w_det[1]) | (w_det[0] & w_det[2]) | (w_det[1] & w_det[2]);
  assign w_code  = w_det[2] ? 2'b11 : (w_det[1] ? 2'b10 : 2'b01);

  // Full is judged on the registered count, so a same-cycle pop does not free a slot.
  assign w_push        = w_any && !w_multi && enable && !fifo_full;
  assign w_pop         = (r_state == ST_IDLE) && (pending != '0);
  assign w_pending_nxt = pending + PW'(w_push) - PW'(w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_code;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      pending     <= '0;
      fifo_full   <= 1'b0;
      coin_reject <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      pending     <= w_pending_nxt;
      fifo_full   <= (w_pending_nxt == PW'(FIFO_DEPTH));
      coin_reject <= w_any && !w_push;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_gap   <= '0;
      moneda  <= 2'b00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          moneda <= 2'b00;
          if (w_pop) begin
            moneda  <= r_mem[r_rptr];
            r_state <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          moneda  <= 2'b00;
          r_gap   <= GW'(MIN_GAP - 1);
          r_state <= ST_GAP;
        end
        ST_GAP: begin
          moneda <= 2'b00;
          if (r_gap == '0) r_state <= ST_IDLE;
          else             r_gap   <= r_gap - GW'(1);
        end
        default: begin
          moneda  <= 2'b00;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_coin_acceptor.sv
// Scoreboard bench for coin_acceptor: a window-based reference model predicts emitted codes,
// rejects and queue depth; a negedge monitor compares whatever the DUT presents.

module tb_coin_acceptor;
  localparam int DEB   = 4;
  localparam int GAP   = 40;
  localparam int DEPTH = 4;
  localparam int PW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          sensor2 = 1'b0, sensor3 = 1'b0, sensor4 = 1'b0;
  logic          enable = 1'b1;
  logic [1:0]    moneda;
  logic          coin_reject;
  logic          fifo_full;
  logic [PW-1:0] pending;

  coin_acceptor #(.DEB_CYCLES(DEB), .MIN_GAP(GAP), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .sensor2(sensor2), .sensor3(sensor3), .sensor4(sensor4),
    .enable(enable), .moneda(moneda), .coin_reject(coin_reject), .fifo_full(fifo_full),
    .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct { int code; int cyc; } emit_t;

  int    nchecks = 0, nerr = 0;
  int    cyc = 0;
  emit_t exp_q[$];
  int    rej_q[$];

  // reference model state
  int       mq[$];
  bit [7:0] hist [3];
  bit       armed [3];
  int       last_pop = -1000;
  int       m_pending = 0;

  // monitor bookkeeping
  int emit_count = 0, rej_count = 0, last_emit_cyc = -1, zeros = 1000;
  bit full_seen = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    nchecks++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a sensor fires when its last DEB synchronised samples are all high
  // while armed, and re-arms when they are all low. Synchronised sample lags raw by 2 edges,
  // and the decision registers one edge after the detect cycle.
  initial begin
    for (int i = 0; i < 3; i++) begin hist[i] = '0; armed[i] = 1'b1; end
    forever begin
      @(posedge clk);
      cyc++;
      if (!reset_n) begin
        mq.delete(); exp_q.delete(); rej_q.delete();
        for (int i = 0; i < 3; i++) begin hist[i] = '0; armed[i] = 1'b1; end
        last_pop = -1000; m_pending = 0;
      end else begin
        automatic bit [2:0] raw = {sensor4, sensor3, sensor2};
        automatic int ndet = 0, dcode = 0, pre = mq.size();
        for (int i = 0; i < 3; i++) begin
          hist[i] = {hist[i][6:0], raw[i]};
          if (armed[i] && hist[i][6:3] == 4'hF) begin
            ndet++; dcode = i + 1; armed[i] = 1'b0;
          end else if (!armed[i] && hist[i][6:3] == 4'h0) begin
            armed[i] = 1'b1;
          end
        end
        if (pre > 0 && cyc - last_pop >= GAP + 2) begin
          automatic emit_t e;
          e.code = mq.pop_front(); e.cyc = cyc;
          exp_q.push_back(e);
          last_pop = cyc;
        end
        if (ndet > 1 || (ndet == 1 && (!enable || pre == DEPTH))) rej_q.push_back(cyc);
        else if (ndet == 1) mq.push_back(dcode);
        m_pending = mq.size();
      end
    end
  end

  initial forever begin
    @(negedge reset_n);
    exp_q.delete(); rej_q.delete(); zeros = 1000;
  end

  // Monitor
  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      if (moneda != 2'b00) begin
        emit_count++;
        chk("code_gap", int'(zeros >= GAP + 1), 1);
        zeros = 0;
        last_emit_cyc = cyc;
        if (exp_q.size() == 0) chk("unexpected_code", int'(moneda), 0);
        else begin
          automatic emit_t e = exp_q.pop_front();
          chk("code_value", int'(moneda), e.code);
          chk("code_cycle", cyc, e.cyc);
        end
      end else zeros++;
      if (coin_reject) begin
        rej_count++;
        if (rej_q.size() == 0) chk("unexpected_reject", 1, 0);
        else chk("reject_cycle", cyc, rej_q.pop_front());
      end
      if (fifo_full) full_seen = 1'b1;
      chk("pending", int'(pending), m_pending);
      chk("fifo_full", int'(fifo_full), int'(m_pending == DEPTH));
    end
  end

  task automatic hold(input bit [2:0] s, input int n);
    {sensor4, sensor3, sensor2} = s;
    repeat (n) begin @(posedge clk); #3; end
  endtask

  initial begin
    int e0, r0, t0;
    // 1: reset with sensors toggling
    @(posedge clk); #3;
    for (int k = 0; k < 8; k++) begin
      {sensor4, sensor3, sensor2} = 3'($urandom_range(0, 7));
      @(posedge clk); #3;
      chk("rst_moneda", int'(moneda), 0);
      chk("rst_pending", int'(pending), 0);
      chk("rst_reject", int'(coin_reject), 0);
    end
    {sensor4, sensor3, sensor2} = 3'b000;
    reset_n = 1'b1;
    hold(3'b000, 12);
    chk("idle_after_reset", emit_count, 0);

    // 2: single coin latency
    e0 = emit_count; t0 = cyc;
    hold(3'b010, 10);
    hold(3'b000, 60);
    chk("single_count", emit_count - e0, 1);
    chk("single_latency", last_emit_cyc, t0 + 1 + DEB + 3);

    // 3: glitch, no re-arm, re-arm
    e0 = emit_count;
    hold(3'b001, 3); hold(3'b000, 10);
    chk("glitch", emit_count - e0, 0);
    hold(3'b001, 6); hold(3'b000, 2); hold(3'b001, 6); hold(3'b000, 60);
    chk("no_rearm", emit_count - e0, 1);
    hold(3'b000, 6); hold(3'b001, 6); hold(3'b000, 60);
    chk("rearm", emit_count - e0, 2);

    // 4: burst while emitter is pacing a previous coin
    e0 = emit_count; r0 = rej_count; full_seen = 1'b0;
    hold(3'b001, 6);
    for (int k = 0; k < 5; k++) begin hold(3'b100, 4); hold(3'b000, 4); end
    hold(3'b000, 5 * (GAP + 2));
    chk("burst_full_seen", int'(full_seen), 1);
    chk("burst_reject", rej_count - r0, 1);
    chk("burst_emits", emit_count - e0, 5);

    // 5: collision and disable
    e0 = emit_count; r0 = rej_count;
    hold(3'b011, 6); hold(3'b000, 10);
    chk("collision_reject", rej_count - r0, 1);
    enable = 1'b0;
    hold(3'b100, 6); hold(3'b000, 10);
    enable = 1'b1;
    chk("disable_reject", rej_count - r0, 2);
    chk("disable_pending", int'(pending), 0);
    chk("reject_no_code", emit_count - e0, 0);

    // 6: async reset with queued coins and emitter pacing
    hold(3'b001, 6);
    for (int k = 0; k < 3; k++) begin hold(3'b100, 4); hold(3'b000, 4); end
    hold(3'b000, 2);
    chk("pre_reset_pending", int'(pending), 3);
    reset_n = 1'b0;
    #1;
    chk("async_moneda", int'(moneda), 0);
    chk("async_pending", int'(pending), 0);
    chk("async_full", int'(fifo_full), 0);
    chk("async_reject", int'(coin_reject), 0);
    hold(3'b000, 3);
    reset_n = 1'b1;
    e0 = emit_count;
    hold(3'b000, 3 * (GAP + 4));
    chk("no_stale_codes", emit_count - e0, 0);

    // random phase
    for (int k = 0; k < 250; k++) begin
      automatic int pick = $urandom_range(0, 9);
      automatic bit [2:0] s = (pick < 7) ? 3'(1 << (pick % 3)) : 3'($urandom_range(0, 7));
      enable = ($urandom_range(0, 9) != 0);
      hold(s, $urandom_range(1, 9));
      hold(3'b000, $urandom_range(1, 9));
    end
    enable = 1'b1;
    hold(3'b000, (DEPTH + 1) * (GAP + 3));
    chk("drain_codes", exp_q.size(), 0);
    chk("drain_rejects", rej_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end
endmodule
